// File: rtl/ravan_pkg.sv
// Shared types and constants for the ravan ingress front end: beat kinds,
// controller states and key/block geometry.
package ravan_pkg;

    localparam int unsigned KEY_WORDS = 8;
    localparam int unsigned BLOCK_W   = 64;
    localparam int unsigned KEY_W     = KEY_WORDS * BLOCK_W;

    typedef enum logic [1:0] {
        KindEnc  = 2'b00,
        KindDec  = 2'b01,
        KindKey  = 2'b10,
        KindRsvd = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        StIdle,
        StKeyLoad,
        StKeySettle,
        StStream
    } state_e;

endpackage

// File: rtl/ravan_sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry reads as zero
// whenever the FIFO is empty.
module ravan_sync_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ravan_ingress.sv
// Ingress controller: assembles a 512-bit key from key beats, waits out the
// hash pipeline, then forwards tagged data blocks through a small FIFO.
module ravan_ingress
    import ravan_pkg::*;
#(
    parameter int unsigned HASH_LAT   = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BLOCK_W-1:0] s_data,
    input  logic [1:0]         s_kind,
    output logic [KEY_W-1:0]   key,
    output logic               key_update,
    output logic [BLOCK_W-1:0] data_in,
    output logic               enc_op_sel,
    output logic               d_valid,
    input  logic               d_ready,
    output logic               err
);

    localparam int unsigned SET_W = (HASH_LAT > 0) ? $clog2(HASH_LAT + 1) : 1;
    localparam logic [2:0]  LAST_WORD = 3'(KEY_WORDS - 1);

    state_e                           state_q, state_d;
    logic [2:0]                       word_q, word_d;
    logic [SET_W-1:0]                 settle_q, settle_d;
    logic [KEY_WORDS-1:0][BLOCK_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0]                 key_q, key_d;
    logic                             key_update_q, key_update_d;
    logic                             err_q, err_d;

    kind_e            kind;
    logic             fifo_push, fifo_full, fifo_empty;
    logic [BLOCK_W:0] fifo_head;

    assign kind = kind_e'(s_kind);

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        settle_d     = settle_q;
        shadow_d     = shadow_q;
        key_d        = key_q;
        key_update_d = 1'b0;
        err_d        = err_q;
        fifo_push    = 1'b0;

        unique case (state_q)
            StIdle, StKeyLoad: s_ready = 1'b1;
            StKeySettle:       s_ready = 1'b0;
            StStream:          s_ready = (kind == KindKey) ? fifo_empty : !fifo_full;
            default:           s_ready = 1'b0;
        endcase

        if (state_q == StKeySettle) begin
            if (settle_q > SET_W'(1)) begin
                settle_d = settle_q - 1'b1;
            end else begin
                settle_d = '0;
                state_d  = StStream;
            end
        end

        if (s_valid && s_ready) begin
            if (kind == KindKey) begin
                if (state_q == StKeyLoad) begin
                    // Word 0 lands in the top slice so the key reads MSB-first.
                    shadow_d[LAST_WORD - word_q] = s_data;
                    if (word_q == LAST_WORD) begin
                        key_d        = shadow_d;
                        key_update_d = 1'b1;
                        settle_d     = SET_W'(HASH_LAT);
                        word_d       = '0;
                        state_d      = StKeySettle;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end else begin
                    shadow_d[LAST_WORD] = s_data;
                    word_d              = 3'd1;
                    state_d             = StKeyLoad;
                end
            end else if (state_q == StStream && kind != KindRsvd) begin
                fifo_push = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            word_q       <= '0;
            settle_q     <= '0;
            shadow_q     <= '0;
            key_q        <= '0;
            key_update_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            settle_q     <= settle_d;
            shadow_q     <= shadow_d;
            key_q        <= key_d;
            key_update_q <= key_update_d;
            err_q        <= err_d;
        end
    end

    ravan_sync_fifo #(
        .WIDTH (BLOCK_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({~s_kind[0], s_data}),
        .full  (fifo_full),
        .pop   (d_ready),
        .rdata (fifo_head),
        .empty (fifo_empty)
    );

    assign key        = key_q;
    assign key_update = key_update_q;
    assign err        = err_q;
    assign d_valid    = !fifo_empty;
    assign data_in    = fifo_head[BLOCK_W-1:0];
    assign enc_op_sel = fifo_head[BLOCK_W];

endmodule

// File: tb/tb_ravan_ingress.sv
// Directed bench for ravan_ingress: a vector table for key load and streaming,
// plus hand sequences for key preemption, errors and asynchronous reset.
module tb_ravan_ingress;

    localparam logic [1:0] K_ENC  = 2'b00;
    localparam logic [1:0] K_DEC  = 2'b01;
    localparam logic [1:0] K_KEY  = 2'b10;
    localparam logic [1:0] K_RSVD = 2'b11;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [63:0]  s_data;
    logic [1:0]   s_kind;
    logic [511:0] key;
    logic         key_update;
    logic [63:0]  data_in;
    logic         enc_op_sel;
    logic         d_valid;
    logic         d_ready;
    logic         err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        valid;
        logic [1:0]  kind;
        logic [63:0] data;
        logic        dready;
        logic        exp_ready;
        logic        exp_dvalid;
        logic [63:0] exp_din;
        logic        exp_enc;
        logic        exp_kupd;
    } vec_t;

    vec_t vq[$];

    ravan_ingress #(
        .HASH_LAT   (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_kind     (s_kind),
        .key        (key),
        .key_update (key_update),
        .data_in    (data_in),
        .enc_op_sel (enc_op_sel),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] build_key(input logic [63:0] base);
        logic [511:0] k;
        k = '0;
        for (int i = 0; i < 8; i++) k[511 - 64 * i -: 64] = base + 64'(i);
        return k;
    endfunction

    task automatic drive(input logic v, input logic [1:0] k, input logic [63:0] d,
                         input logic dr);
        @(negedge clk);
        s_valid = v;
        s_kind  = k;
        s_data  = d;
        d_ready = dr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_keys(input logic [63:0] base, input int first, input int last,
                             output int pulses);
        pulses = 0;
        for (int i = first; i <= last; i++) begin
            drive(1'b1, K_KEY, base + 64'(i), 1'b1);
            check($sformatf("key word %0d s_ready", i), s_ready, 1'b1);
            tick();
            if (key_update) pulses++;
        end
    endtask

    task automatic settle_check();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, K_ENC, 64'h0, 1'b1);
            check($sformatf("settle %0d s_ready", i), s_ready, 1'b0);
            tick();
            check($sformatf("settle %0d key_update", i), key_update, 1'b0);
        end
        drive(1'b0, K_ENC, 64'h0, 1'b1);
        check("stream entry s_ready", s_ready, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_ready"}, s_ready, 1'b1);
        check({tag, " d_valid"}, d_valid, 1'b0);
        check({tag, " data_in"}, data_in, 64'h0);
        check({tag, " enc_op_sel"}, enc_op_sel, 1'b0);
        check({tag, " key"}, key, 512'h0);
        check({tag, " key_update"}, key_update, 1'b0);
        check({tag, " err"}, err, 1'b0);
    endtask

    initial begin
        int p;
        vec_t v;

        // Key load, settle window, single beat, backpressure, full throughput.
        for (int i = 0; i < 8; i++)
            vq.push_back('{1'b1, K_KEY, 64'(i + 1), 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'(i == 7)});
        for (int i = 0; i < 4; i++)
            vq.push_back('{1'b0, K_ENC, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0});
        vq.push_back('{1'b1, K_ENC, 64'hDEADBEEF00000000, 1'b1, 1'b1, 1'b1,
                       64'hDEADBEEF00000000, 1'b1, 1'b0});
        vq.push_back('{1'b0, K_ENC, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0});
        vq.push_back('{1'b1, K_DEC, 64'h1111, 1'b0, 1'b1, 1'b1, 64'h1111, 1'b0, 1'b0});
        vq.push_back('{1'b1, K_ENC, 64'h2222, 1'b0, 1'b1, 1'b1, 64'h1111, 1'b0, 1'b0});
        vq.push_back('{1'b1, K_DEC, 64'h3333, 1'b0, 1'b0, 1'b1, 64'h1111, 1'b0, 1'b0});
        vq.push_back('{1'b1, K_DEC, 64'h3333, 1'b1, 1'b0, 1'b1, 64'h2222, 1'b1, 1'b0});
        vq.push_back('{1'b1, K_DEC, 64'h3333, 1'b1, 1'b1, 1'b1, 64'h3333, 1'b0, 1'b0});
        vq.push_back('{1'b0, K_ENC, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0});
        vq.push_back('{1'b1, K_ENC, 64'h44, 1'b1, 1'b1, 1'b1, 64'h44, 1'b1, 1'b0});
        vq.push_back('{1'b1, K_ENC, 64'h55, 1'b1, 1'b1, 1'b1, 64'h55, 1'b1, 1'b0});
        vq.push_back('{1'b0, K_ENC, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0});

        s_valid = 1'b0;
        s_kind  = K_ENC;
        s_data  = 64'h0;
        d_ready = 1'b0;
        rst     = 1'b1;
        #2 rst  = 1'b0;
        #1 check_reset_outputs("reset t0");
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset held");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.valid, v.kind, v.data, v.dready);
            check($sformatf("v%0d s_ready", i), s_ready, v.exp_ready);
            tick();
            check($sformatf("v%0d d_valid", i), d_valid, v.exp_dvalid);
            check($sformatf("v%0d data_in", i), data_in, v.exp_din);
            check($sformatf("v%0d enc_op_sel", i), enc_op_sel, v.exp_enc);
            check($sformatf("v%0d key_update", i), key_update, v.exp_kupd);
            check($sformatf("v%0d err", i), err, 1'b0);
        end
        check("key after first load", key, build_key(64'h1));

        // Key beat is held off while the FIFO holds data, then reloads the key.
        drive(1'b1, K_ENC, 64'hAA, 1'b0);
        tick();
        check("preempt data d_valid", d_valid, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, K_KEY, 64'h10, 1'b0);
            check($sformatf("preempt blocked %0d s_ready", i), s_ready, 1'b0);
            tick();
        end
        drive(1'b1, K_KEY, 64'h10, 1'b1);
        check("preempt draining s_ready", s_ready, 1'b0);
        tick();
        check("preempt drained d_valid", d_valid, 1'b0);
        send_keys(64'h10, 0, 6, p);
        check("preempt old key held", key, build_key(64'h1));
        check("preempt no early pulse", p, 0);
        send_keys(64'h10, 7, 7, p);
        check("preempt key_update pulses", p, 1);
        check("preempt new key", key, build_key(64'h10));
        settle_check();

        // Asynchronous reset with a block waiting at the FIFO head.
        drive(1'b1, K_ENC, 64'hBB, 1'b0);
        tick();
        check("pre-reset d_valid", d_valid, 1'b1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async reset stream");
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;

        // Protocol errors: data in IDLE, data mid-key, reserved in STREAM.
        drive(1'b1, K_ENC, 64'hCC, 1'b1);
        check("idle data s_ready", s_ready, 1'b1);
        tick();
        check("idle data err", err, 1'b1);
        check("idle data d_valid", d_valid, 1'b0);
        send_keys(64'h30, 0, 2, p);
        drive(1'b1, K_DEC, 64'hDD, 1'b1);
        check("keyload data s_ready", s_ready, 1'b1);
        tick();
        check("keyload data d_valid", d_valid, 1'b0);
        send_keys(64'h30, 3, 7, p);
        check("key with interleaved error", key, build_key(64'h30));
        check("err sticky through load", err, 1'b1);
        settle_check();
        drive(1'b1, K_RSVD, 64'hEE, 1'b1);
        check("reserved s_ready", s_ready, 1'b1);
        tick();
        check("reserved d_valid", d_valid, 1'b0);
        check("reserved err", err, 1'b1);
        drive(1'b0, K_ENC, 64'h0, 1'b1);
        tick();
        tick();
        check("err still sticky", err, 1'b1);
        check("dropped beats d_valid", d_valid, 1'b0);

        // Reset partway through a key, then a full reload.
        send_keys(64'h40, 0, 4, p);
        check("partial key not visible", key, build_key(64'h30));
        #2 rst = 1'b0;
        #1 check_reset_outputs("async reset mid-key");
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        send_keys(64'h50, 0, 7, p);
        check("reload key_update pulses", p, 1);
        check("reload key", key, build_key(64'h50));
        settle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
